// File: rtl/aes_word_loader.sv
// -----------------------------------------------------------------------------
// aes_word_loader
//
// Streams a 128-bit key and a 128-bit plaintext block into an external aes_128
// core as 32-bit words, waits a fixed core latency, then streams the 128-bit
// ciphertext back out as four 32-bit words. A block may reuse the previously
// stored key (key_keep=1 on its first word), in which case only the four state
// words are accepted.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   asynchronous, active-low reset
//   key_keep    in   sampled with the first word of a block: 1 = reuse key
//   in_valid    in   in_data carries a word
//   in_ready    out  loader accepts a word this cycle
//   in_data     in   32-bit word; key words then state words, MS word first
//   core_state  out  registered 128-bit state to the core
//   core_key    out  registered 128-bit key to the core
//   core_out    in   128-bit ciphertext from the core
//   out_valid   out  out_data holds a ciphertext word
//   out_ready   in   consumer accepts out_data
//   out_data    out  32-bit ciphertext word, MS word first
//   out_last    out  marks the 4th (least-significant) ciphertext word
//   busy        out  high whenever the loader is not idle
// -----------------------------------------------------------------------------
module aes_word_loader #(
   parameter int CORE_LAT = 21,  // cycles from core sampling its inputs to valid core_out
   parameter int CNT_W    = 5    // latency counter width, 2**CNT_W > CORE_LAT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         key_keep,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   output logic [127:0] core_state,
   output logic [127:0] core_key,
   input  logic [127:0] core_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_data,
   output logic         out_last,
   output logic         busy
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_KEY,
      LOAD_STATE,
      ISSUE,
      WAIT,
      DRAIN
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        idx_q,   idx_d;    // word index, shared by load and drain phases
   logic [CNT_W-1:0]  cnt_q,   cnt_d;    // remaining core latency
   logic [127:0]      key_q,   key_d;
   logic [127:0]      st_q,    st_d;
   logic [127:0]      buf_q,   buf_d;    // captured ciphertext

   logic in_fire;
   logic out_fire;

   // Word 0 is the most-significant word (bits 127:96).
   function automatic logic [127:0] word_put(input logic [127:0] v,
                                             input logic [1:0]   i,
                                             input logic [31:0]  w);
      logic [127:0] r;
      r = v;
      case (i)
         2'd0:    r[127:96] = w;
         2'd1:    r[95:64]  = w;
         2'd2:    r[63:32]  = w;
         default: r[31:0]   = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] word_get(input logic [127:0] v,
                                            input logic [1:0]   i);
      logic [31:0] r;
      case (i)
         2'd0:    r = v[127:96];
         2'd1:    r = v[95:64];
         2'd2:    r = v[63:32];
         default: r = v[31:0];
      endcase
      return r;
   endfunction

   assign in_fire  = in_valid  & in_ready;
   assign out_fire = out_valid & out_ready;

   // ---------------------------------------------------------------------------
   // State register (FSM state plus the datapath registers it steers)
   // ---------------------------------------------------------------------------
   // NOTE: every register clears on reset, including the 128-bit key, state and
   // ciphertext buffer: a key_keep block issued straight after reset must see an
   // all-zero key, and no stale ciphertext may be visible on out_data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         key_q   <= '0;
         st_q    <= '0;
         buf_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         st_q    <= st_d;
         buf_q   <= buf_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: hold-value defaults first, so no path through the case infers a latch.
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      st_d    = st_q;
      buf_d   = buf_q;

      unique case (state_q)
         IDLE: begin
            // key_keep only matters on the first word of a block.
            if (in_fire) begin
               idx_d = 2'd1;
               if (key_keep) begin
                  st_d    = word_put(st_q, 2'd0, in_data);
                  state_d = LOAD_STATE;
               end else begin
                  key_d   = word_put(key_q, 2'd0, in_data);
                  state_d = LOAD_KEY;
               end
            end
         end

         LOAD_KEY: begin
            if (in_fire) begin
               key_d = word_put(key_q, idx_q, in_data);
               idx_d = idx_q + 2'd1;   // wraps to 0 entering LOAD_STATE
               if (idx_q == 2'd3) state_d = LOAD_STATE;
            end
         end

         LOAD_STATE: begin
            if (in_fire) begin
               st_d  = word_put(st_q, idx_q, in_data);
               idx_d = idx_q + 2'd1;   // wraps to 0, ready for DRAIN
               if (idx_q == 2'd3) state_d = ISSUE;
            end
         end

         ISSUE: begin
            // The core samples the complete key/state at the end of this cycle;
            // counting CORE_LAT-1 down to 0 lands the capture CORE_LAT cycles later.
            cnt_d   = CNT_W'(CORE_LAT - 1);
            state_d = WAIT;
         end

         WAIT: begin
            if (cnt_q == '0) begin
               buf_d   = core_out;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         DRAIN: begin
            if (out_fire) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      busy      = 1'b1;

      unique case (state_q)
         IDLE: begin
            // Reset holds the FSM in IDLE; gating keeps in_ready low while it is asserted.
            in_ready = reset;
            busy     = 1'b0;
         end
         LOAD_KEY,
         LOAD_STATE: in_ready = 1'b1;
         DRAIN: begin
            out_valid = 1'b1;
            out_last  = (idx_q == 2'd3);
         end
         default: ;
      endcase
   end

   assign out_data   = word_get(buf_q, idx_q);
   assign core_state = st_q;
   assign core_key   = key_q;

endmodule

// File: tb/tb_aes_word_loader.sv
// -----------------------------------------------------------------------------
// tb_aes_word_loader
//
// Drives directed and randomized word blocks into aes_word_loader. A behavioural
// AES-128 core with a CORE_LAT-deep output pipeline stands in for the real core;
// expected ciphertext comes from the same reference function applied to the
// key/state the bench itself sent, and is cross-checked against FIPS-197 vectors.
// -----------------------------------------------------------------------------
module tb_aes_word_loader;

   localparam int CORE_LAT = 21;
   localparam int CNT_W    = 5;

   localparam logic [127:0] KAT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KAT_PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KAT_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic         clk       = 1'b0;
   logic         reset     = 1'b0;
   logic         key_keep  = 1'b0;
   logic         in_valid  = 1'b0;
   logic [31:0]  in_data   = '0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic [127:0] core_state;
   logic [127:0] core_key;
   logic [127:0] core_out;
   logic         out_valid;
   logic [31:0]  out_data;
   logic         out_last;
   logic         busy;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]   sbox [256];
   logic [127:0] pipe [CORE_LAT];
   logic [127:0] model_key = '0;   // key the loader should be holding
   logic [127:0] obs_ct;           // ciphertext words as transferred out

   always #5 clk = ~clk;

   aes_word_loader #(
      .CORE_LAT (CORE_LAT),
      .CNT_W    (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_keep   (key_keep),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .core_state (core_state),
      .core_key   (core_key),
      .core_out   (core_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy)
   );

   // ---------------------------------------------------------------------------
   // Reference AES-128
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rcon;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp  = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
                   ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               s[row + 4*c] = t[row + 4*((c + row) % 4)];
         if (rd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Core stand-in: samples key/state every edge, result emerges CORE_LAT edges later.
   always @(posedge clk) begin
      pipe[0] <= aes128(core_state, core_key);
      for (int i = 1; i < CORE_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign core_out = pipe[CORE_LAT-1];

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w, input logic kk);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = w;
      key_keep = kk;
      while (in_ready !== 1'b1 && waited < 100) begin
         tick();
         waited++;
      end
      check("in_ready_wait_bound", waited < 100, 1'b1);
      tick();
      in_valid = 1'b0;
      in_data  = $urandom;
      key_keep = 1'($urandom_range(1, 0));
   endtask

   task automatic run_block(input logic keep, input logic [127:0] key, input logic [127:0] st,
                            input int gap_lo, input int gap_hi, input int stall_first,
                            input bit rand_ready);
      logic [31:0]  words [$];
      logic [127:0] exp_ct;
      int           lat;
      logic         saw_ready;
      int           stalls;
      if (!keep) begin
         model_key = key;
         for (int i = 0; i < 4; i++) words.push_back(key[127-32*i -: 32]);
      end
      for (int i = 0; i < 4; i++) words.push_back(st[127-32*i -: 32]);
      exp_ct = aes128(st, model_key);

      // Later words carry random key_keep, which the loader must ignore.
      foreach (words[i]) begin
         send_word(words[i], (i == 0) ? keep : 1'($urandom_range(1, 0)));
         if (i != words.size() - 1) repeat ($urandom_range(gap_hi, gap_lo)) tick();
      end

      // ISSUE cycle
      check("issue_in_ready",  in_ready,   1'b0);
      check("issue_busy",      busy,       1'b1);
      check("issue_out_valid", out_valid,  1'b0);
      check("issue_core_key",  core_key,   model_key);
      check("issue_core_state", core_state, st);

      // Junk offered during ISSUE/WAIT must be ignored.
      in_valid  = 1'b1;
      in_data   = $urandom;
      lat       = 0;
      saw_ready = 1'b0;
      while (out_valid !== 1'b1 && lat < 100) begin
         saw_ready = saw_ready | in_ready;
         tick();
         in_data = $urandom;
         lat++;
      end
      in_valid = 1'b0;
      check("issue_to_out_latency", lat, CORE_LAT + 1);
      check("wait_in_ready",        saw_ready, 1'b0);
      check("hold_core_key",        core_key, model_key);
      check("hold_core_state",      core_state, st);

      for (int w = 0; w < 4; w++) begin
         stalls = 0;
         forever begin
            check("out_valid",      out_valid, 1'b1);
            check("out_data",       out_data,  exp_ct[127-32*w -: 32]);
            check("out_last",       out_last,  w == 3);
            check("drain_in_ready", in_ready,  1'b0);
            if (w == 0 && stalls < stall_first) out_ready = 1'b0;
            else if (rand_ready && stalls < 8)  out_ready = 1'($urandom_range(1, 0));
            else                                out_ready = 1'b1;
            obs_ct[127-32*w -: 32] = out_data;
            tick();
            if (out_ready) break;
            stalls++;
         end
      end
      out_ready = 1'b0;
      check("post_busy",      busy,      1'b0);
      check("post_in_ready",  in_ready,  1'b1);
      check("post_out_valid", out_valid, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},   in_ready,   1'b0);
      check({tag, "_out_valid"},  out_valid,  1'b0);
      check({tag, "_out_last"},   out_last,   1'b0);
      check({tag, "_busy"},       busy,       1'b0);
      check({tag, "_core_state"}, core_state, 128'h0);
      check({tag, "_core_key"},   core_key,   128'h0);
      check({tag, "_out_data"},   out_data,   32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Directed and random steps
   // ---------------------------------------------------------------------------
   initial begin
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end

      // Reset state
      #2;
      check_reset_outputs("reset");
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("release_in_ready", in_ready, 1'b1);
      check("release_busy",     busy,     1'b0);

      // key_keep first after reset: key must be zero
      run_block(1'b1, {$urandom, $urandom, $urandom, $urandom}, 128'h0, 0, 0, 0, 1'b0);
      check("kat_zero_key", obs_ct, ZERO_CT);

      // Full 8-word block, out_ready always high
      run_block(1'b0, KAT_KEY, KAT_PT, 0, 0, 0, 1'b0);
      check("kat_full_block", obs_ct, KAT_CT);

      // Reuse the stored key
      run_block(1'b1, 128'h0, KAT_PT, 0, 0, 0, 1'b0);
      check("kat_key_keep", obs_ct, KAT_CT);

      // Consumer stalls 10 cycles on the first word
      run_block(1'b1, 128'h0, KAT_PT, 0, 0, 10, 1'b0);
      check("kat_stall", obs_ct, KAT_CT);

      // in_valid toggling every cycle during load
      run_block(1'b0, KAT_KEY, KAT_PT, 1, 1, 0, 1'b0);
      check("kat_toggle", obs_ct, KAT_CT);

      // Reset after five input words
      for (int i = 0; i < 4; i++) send_word(KAT_KEY[127-32*i -: 32], (i == 0) ? 1'b0 : 1'b1);
      send_word(KAT_PT[127:96], 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("midblock_reset");
      model_key = '0;
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("midblock_release_in_ready", in_ready, 1'b1);
      check("midblock_release_busy",     busy,     1'b0);
      run_block(1'b0, KAT_KEY, KAT_PT, 0, 1, 0, 1'b1);
      check("kat_after_reset", obs_ct, KAT_CT);

      // Randomized blocks
      for (int b = 0; b < 12; b++) begin
         run_block(1'($urandom_range(1, 0)),
                   {$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom},
                   0, 3, 0, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_word_loader.md
AES_WORD_LOADER -- requirements
Module: aes_word_loader

Interface
REQ-001 Parameter CORE_LAT, default 21: cycles from core_state/core_key sampled by the core to the valid core_out.
REQ-002 Parameter CNT_W, default 5: width of the latency counter; SHALL satisfy 2^CNT_W > CORE_LAT.
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 key_keep  input  1  1 = reuse the stored key; only 4 state words accepted per block.
REQ-006 in_valid  input  1  in_data carries a word.
REQ-007 in_ready  output  1  loader accepts a word this cycle.
REQ-008 in_data  input  32  word; key words first, then state words, most-significant word first.
REQ-009 core_state  output  128  registered state to the aes_128 core.
REQ-010 core_key  output  128  registered key to the aes_128 core.
REQ-011 core_out  input  128  ciphertext from the aes_128 core.
REQ-012 out_valid  output  1  out_data holds a ciphertext word.
REQ-013 out_ready  input  1  consumer accepts out_data.
REQ-014 out_data  output  32  ciphertext word, most-significant word first.
REQ-015 out_last  output  1  high with the 4th (least-significant) ciphertext word.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_KEY, LOAD_STATE, ISSUE, WAIT, DRAIN.
REQ-018 A word transfers on in_valid&in_ready; in_ready SHALL be high only in IDLE, LOAD_KEY and LOAD_STATE.
REQ-019 IDLE, first accepted word: key_keep=0 -> load as key word 0 (bits 127:96), go LOAD_KEY; key_keep=1 -> load as state word 0, go LOAD_STATE.
REQ-020 key_keep SHALL be sampled only on the first word of a block; later changes in that block are ignored.
REQ-021 LOAD_KEY SHALL accept key words 1..3 into core_key; after word 3 go LOAD_STATE.
REQ-022 LOAD_STATE SHALL accept state words into core_state until 4 are held, then go ISSUE.
REQ-023 The word index SHALL be 2 bits and wrap 3->0 on each phase change.
REQ-024 ISSUE SHALL last exactly one cycle, load the latency counter with CORE_LAT-1, and go WAIT.
REQ-025 core_state/core_key SHALL hold constant from ISSUE until core_out is captured.
REQ-026 WAIT SHALL decrement the counter each cycle; at count 0, capture core_out into a 128-bit output buffer and go DRAIN; core_out is then exactly CORE_LAT cycles after ISSUE.
REQ-027 DRAIN: out_valid=1, out_data = buffer word at index (0 = bits 127:96); index advances on out_valid&out_ready.
REQ-028 out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 The 4th transfer SHALL return the FSM to IDLE; in_ready may rise the following cycle (no same-cycle in/out overlap).
REQ-030 in_valid SHALL be ignored outside load states; the stored key SHALL persist across blocks until overwritten by a key_keep=0 block.
REQ-031 key_keep=1 with no key loaded since reset SHALL use core_key = 0.

Reset
REQ-032 reset low SHALL asynchronously force state IDLE and all indices/counter to 0.
REQ-033 reset low SHALL asynchronously force core_state, core_key and the output buffer to 0.
REQ-034 reset low SHALL asynchronously force in_ready=0, out_valid=0, out_last=0, busy=0.
REQ-035 Reset mid-block SHALL discard all partial input and pending output; the first cycle after release is IDLE with in_ready=1.

Verification
REQ-036 Key 000102030405060708090a0b0c0d0e0f, state 00112233445566778899aabbccddeeff, out_ready=1 -> ISSUE after 8 words; out words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a exactly CORE_LAT+1 cycles later, out_last on the 4th.
REQ-037 Same block, then 4 state words with key_keep=1 -> identical ciphertext, no key words consumed.
REQ-038 out_ready held 0 for 10 cycles in DRAIN -> out_data frozen at 69c4e0d8, in_ready=0, no word lost.
REQ-039 reset low after 5 input words -> all outputs 0; a fresh 8-word block after release yields correct ciphertext.
REQ-040 in_valid toggled 1/0 each cycle during load -> exactly 8 words accepted, ISSUE one cycle after the 8th.
REQ-041 key_keep=1 as first block after reset, state all-zero -> core_key=0 at ISSUE; out = 66e94bd4ef8a2c3b884cfa59ca342b2e.
